// File: rtl/mixer_sched_pkg.sv
// Shared widths, channel-index width and the tag type for the mixer scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mixer_sched_pkg;

    localparam int N_CH_DEF    = 4;
    localparam int DW_DEF      = 16;
    localparam int NCO_W_DEF   = 18;
    localparam int OUT_W_DEF   = 20;
    localparam int MIX_LAT_DEF = 2;

    // Largest supported channel count; the tag carries an index wide enough for it
    // so one tag type serves every legal N_CH.
    localparam int N_CH_MAX = 8;
    localparam int CH_W     = $clog2(N_CH_DEF);
    localparam int TAG_CH_W = $clog2(N_CH_MAX);

    typedef struct packed {
        logic                vld;
        logic [TAG_CH_W-1:0] ch;
    } tag_t;

    function automatic tag_t make_tag(input logic vld, input logic [TAG_CH_W-1:0] ch);
        tag_t t;
        t.vld = vld;
        t.ch  = vld ? ch : '0;
        return t;
    endfunction

endpackage

// File: rtl/mixer_rr_arbiter.sv
// Round-robin arbiter: first requester after the last grant wins.
// Latency: grant is combinational from req; pointer updates at the grant edge.
// Backpressure: none; a grant is always accepted.
module mixer_rr_arbiter #(
    parameter int N_CH = 4,
    parameter int IW   = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    output logic            grant_vld,
    output logic [IW-1:0]   grant_idx
);

    logic [IW-1:0] ptr;
    int            j;

    // Scan offsets from far to near so the nearest requester after ptr is the last write and wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int i = N_CH; i >= 1; i--) begin
            j = int'(ptr) + i;
            if (j >= N_CH) begin
                j = j - N_CH;
            end
            if (req[j[IW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = j[IW-1:0];
            end
        end
    end

    // Pointer follows the most recent grant; held when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IW'(N_CH - 1);
        end else if (grant_vld) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/mixer_iq_scheduler.sv
// Time-shares one mixer between N_CH streams via 1-deep holds, RR grant and a tag pipe.
// Latency: s_valid -> m_valid is 3+MIX_LAT clocks uncontended; 1 result per clock.
// Backpressure: none; a load onto an ungranted full hold overwrites it and sets ovf.
// Optional: define MIX_SCHED_CNT_EN for saturating per-channel drop counters.
module mixer_iq_scheduler
    import mixer_sched_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int DW      = DW_DEF,
    parameter int NCO_W   = NCO_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int MIX_LAT = MIX_LAT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           ch_en,
    input  logic [N_CH-1:0]           s_valid,
    input  logic [N_CH*DW-1:0]        s_data,
    input  logic [N_CH*NCO_W-1:0]     nco_i,
    input  logic [N_CH*NCO_W-1:0]     nco_q,
    input  logic                      ovf_clr,
    output logic [DW-1:0]             mix_in,
    output logic [NCO_W-1:0]          mix_nco_i,
    output logic [NCO_W-1:0]          mix_nco_q,
    input  logic [OUT_W-1:0]          mix_o_i,
    input  logic [OUT_W-1:0]          mix_o_q,
    output logic                      m_valid,
    output logic [$clog2(N_CH)-1:0]   m_ch,
    output logic [OUT_W-1:0]          m_i,
    output logic [OUT_W-1:0]          m_q,
    output logic [N_CH-1:0]           ovf,
    output logic [N_CH*16-1:0]        drop_cnt
);

    localparam int CHW = $clog2(N_CH);

    logic [N_CH-1:0] hold_full;
    logic [DW-1:0]   hold_dat [N_CH];

    logic [N_CH-1:0] req;
    logic [N_CH-1:0] gnt_oh;
    logic [N_CH-1:0] load;
    logic [N_CH-1:0] ovr;
    logic            grant_vld;
    logic [CHW-1:0]  grant_idx;

    tag_t            tag_pipe [MIX_LAT+1];
    tag_t            tag_out;
    logic            tag_ch_unused;

    // A disabled channel never requests, even during the cycle its hold is being flushed.
    assign req  = hold_full & ch_en;
    assign load = s_valid & ch_en;
    // Reloading in the same cycle the hold is granted is a clean hand-off, not an overwrite.
    assign ovr  = load & hold_full & ~gnt_oh;

    mixer_rr_arbiter #(
        .N_CH (N_CH),
        .IW   (CHW)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    // One-hot form of the grant for the per-channel hold update.
    always_comb begin
        gnt_oh = '0;
        if (grant_vld) begin
            gnt_oh[grant_idx] = 1'b1;
        end
    end

    // Hold registers: newest sample wins; grant empties unless reloaded; disable flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= '0;
            for (int k = 0; k < N_CH; k++) begin
                hold_dat[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (!ch_en[k]) begin
                    hold_full[k] <= 1'b0;
                end else if (load[k]) begin
                    hold_full[k] <= 1'b1;
                    hold_dat[k]  <= s_data[k*DW +: DW];
                end else if (gnt_oh[k]) begin
                    hold_full[k] <= 1'b0;
                end
            end
        end
    end

    // Mixer operands: register the granted sample with its channel's live NCO words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_in    <= '0;
            mix_nco_i <= '0;
            mix_nco_q <= '0;
        end else if (grant_vld) begin
            mix_in    <= hold_dat[grant_idx];
            mix_nco_i <= nco_i[grant_idx*NCO_W +: NCO_W];
            mix_nco_q <= nco_q[grant_idx*NCO_W +: NCO_W];
        end
    end

    // Tag pipe: stage 0 lines up with mix_*, the last stage with the mixer's result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= MIX_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= make_tag(grant_vld, TAG_CH_W'(grant_idx));
            for (int i = 1; i <= MIX_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out       = tag_pipe[MIX_LAT];
    // Upper tag index bits are only meaningful for the largest channel counts.
    assign tag_ch_unused = ^tag_out.ch;

    // Result registers: data only captured with a valid tag so idle outputs stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_ch    <= '0;
            m_i     <= '0;
            m_q     <= '0;
        end else begin
            m_valid <= tag_out.vld;
            if (tag_out.vld) begin
                m_ch <= CHW'(tag_out.ch);
                m_i  <= mix_o_i;
                m_q  <= mix_o_q;
            end
        end
    end

    // Sticky overwrite flags; a clear wins over a set in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= '0;
        end else if (ovf_clr) begin
            ovf <= '0;
        end else begin
            ovf <= ovf | ovr;
        end
    end

`ifdef MIX_SCHED_CNT_EN
    logic [15:0] cnt [N_CH];

    // Saturating drop counters, cleared together with the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (ovf_clr) begin
                    cnt[k] <= '0;
                end else if (ovr[k] && (cnt[k] != 16'hFFFF)) begin
                    cnt[k] <= cnt[k] + 16'd1;
                end
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        drop_cnt = '0;
        for (int k = 0; k < N_CH; k++) begin
            drop_cnt[k*16 +: 16] = cnt[k];
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mixer_iq_scheduler.sv
// Directed bench for mixer_iq_scheduler with a behavioural two-stage mixer_to_iq.
// Latency: the mixer model registers product then shift, two clocks from mix_* to mix_o_*.
// Backpressure: none; results are logged at the falling edge.
module tb_mixer_iq_scheduler;

    localparam int N_CH  = 4;
    localparam int DW    = 16;
    localparam int NCO_W = 18;
    localparam int OUT_W = 20;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       ch_en;
    logic [N_CH-1:0]       s_valid;
    logic [N_CH*DW-1:0]    s_data;
    logic [N_CH*NCO_W-1:0] nco_i;
    logic [N_CH*NCO_W-1:0] nco_q;
    logic                  ovf_clr;
    logic [DW-1:0]         mix_in;
    logic [NCO_W-1:0]      mix_nco_i;
    logic [NCO_W-1:0]      mix_nco_q;
    logic [OUT_W-1:0]      mix_o_i = '0;
    logic [OUT_W-1:0]      mix_o_q = '0;
    logic                  m_valid;
    logic [1:0]            m_ch;
    logic [OUT_W-1:0]      m_i;
    logic [OUT_W-1:0]      m_q;
    logic [N_CH-1:0]       ovf;
    logic [N_CH*16-1:0]    drop_cnt;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int q_ch [$];
    int q_i  [$];
    int q_q  [$];
    int q_cyc[$];

    always #5 clk = ~clk;

    mixer_iq_scheduler #(
        .N_CH(N_CH), .DW(DW), .NCO_W(NCO_W), .OUT_W(OUT_W), .MIX_LAT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .s_valid(s_valid), .s_data(s_data),
        .nco_i(nco_i), .nco_q(nco_q), .ovf_clr(ovf_clr),
        .mix_in(mix_in), .mix_nco_i(mix_nco_i), .mix_nco_q(mix_nco_q),
        .mix_o_i(mix_o_i), .mix_o_q(mix_o_q),
        .m_valid(m_valid), .m_ch(m_ch), .m_i(m_i), .m_q(m_q),
        .ovf(ovf), .drop_cnt(drop_cnt)
    );

    // Mixer model: deliberately not reset so stale products sit in it across DUT resets.
    logic signed [DW+NCO_W-1:0] p_i = '0;
    logic signed [DW+NCO_W-1:0] p_q = '0;
    always @(posedge clk) begin
        p_i     <= 34'($signed(mix_in)) * 34'($signed(mix_nco_i));
        p_q     <= 34'($signed(mix_in)) * 34'($signed(mix_nco_q));
        mix_o_i <= OUT_W'(p_i >>> 14);
        mix_o_q <= OUT_W'(p_q >>> 14);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Result log.
    always @(negedge clk) begin
        if (m_valid) begin
            q_ch.push_back(int'(m_ch));
            q_i.push_back(int'($signed(m_i)));
            q_q.push_back(int'($signed(m_q)));
            q_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_nco(input int k, input int iv, input int qv);
        nco_i[k*NCO_W +: NCO_W] = NCO_W'(iv);
        nco_q[k*NCO_W +: NCO_W] = NCO_W'(qv);
    endtask

    task automatic set_dat(input int k, input int v);
        s_data[k*DW +: DW] = DW'(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    function automatic int cnt_ch(input int base, input int ch);
        int n = 0;
        for (int i = base; i < q_ch.size(); i++) begin
            if (q_ch[i] == ch) n++;
        end
        return n;
    endfunction

    function automatic int drop_sum();
        int s = 0;
        for (int k = 0; k < N_CH; k++) begin
            s += int'(drop_cnt[k*16 +: 16]);
        end
        return s;
    endfunction

    int base;
    int c0;

    initial begin
        rst_n   = 1'b0;
        ch_en   = 4'hF;
        s_valid = '0;
        s_data  = '0;
        ovf_clr = 1'b0;
        nco_i   = '0;
        nco_q   = '0;
        for (int k = 0; k < N_CH; k++) set_nco(k, 16384, -16384);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Reset state.
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_mix_in", int'(mix_in), 0);
        chk("rst_m_i", int'(m_i), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_drop", drop_sum(), 0);

        // 1: single sample on ch1, latency and mixer arithmetic.
        set_nco(1, 131071, 0);
        set_dat(1, 1000);
        base = q_ch.size();
        c0 = cyc;
        s_valid = 4'b0010;
        tick(1);
        s_valid = '0;
        tick(1);
        chk("t1_mix_in", int'(mix_in), 1000);
        chk("t1_mix_nco_i", int'(mix_nco_i), 131071);
        tick(2);
        chk("t1_m_valid_early", int'(m_valid), 0);
        tick(1);
        chk("t1_m_valid", int'(m_valid), 1);
        chk("t1_m_ch", int'(m_ch), 1);
        chk("t1_m_i", int'($signed(m_i)), 7999);
        chk("t1_m_q", int'($signed(m_q)), 0);
        tick(1);
        chk("t1_count", q_ch.size() - base, 1);
        if (q_cyc.size() > base) chk("t1_latency", q_cyc[base] - c0, 5);
        set_nco(1, 16384, -16384);

        // 2: all four at once from a fresh pointer -> 0,1,2,3 back to back.
        do_reset();
        for (int k = 0; k < N_CH; k++) set_dat(k, 100 * (k + 1));
        base = q_ch.size();
        s_valid = 4'hF;
        tick(1);
        s_valid = '0;
        tick(10);
        chk("t2_count", q_ch.size() - base, 4);
        if (q_ch.size() >= base + 4) begin
            for (int k = 0; k < N_CH; k++) begin
                chk($sformatf("t2_ch%0d", k), q_ch[base+k], k);
                chk($sformatf("t2_i%0d", k), q_i[base+k], 100 * (k + 1));
                chk($sformatf("t2_q%0d", k), q_q[base+k], -100 * (k + 1));
            end
            chk("t2_span", q_cyc[base+3] - q_cyc[base], 3);
        end
        chk("t2_ovf", int'(ovf), 0);

        // 3: ch2 every clock -> full rate, no overwrite.
        set_dat(2, 7);
        base = q_ch.size();
        s_valid = 4'b0100;
        tick(10);
        s_valid = '0;
        tick(10);
        chk("t3_count", q_ch.size() - base, 10);
        chk("t3_ch2", cnt_ch(base, 2), 10);
        if (q_ch.size() >= base + 10) begin
            chk("t3_span", q_cyc[base+9] - q_cyc[base], 9);
            chk("t3_i", q_i[base+5], 7);
        end
        chk("t3_ovf", int'(ovf), 0);

        // 4: all four every clock for 8 clocks -> 7 grants while loading, 4 to drain, 21 overwrites.
        base = q_ch.size();
        s_valid = 4'hF;
        tick(8);
        s_valid = '0;
        tick(12);
        chk("t4_ovf", int'(ovf), 15);
        chk("t4_count", q_ch.size() - base, 11);
`ifdef MIX_SCHED_CNT_EN
        chk("t4_drop_sum", drop_sum(), 21);
`else
        chk("t4_drop_off", drop_sum(), 0);
`endif
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", int'(ovf), 0);
        chk("t4_drop_clr", drop_sum(), 0);

        // 4b: clear coincident with three overwrites -> clear wins.
        s_valid = 4'hF;
        tick(1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        s_valid = '0;
        chk("t4b_ovf_prio", int'(ovf), 0);
        chk("t4b_drop_prio", drop_sum(), 0);
        tick(10);

        // 5: disable ch3 while its hold is full and others keep loading.
        do_reset();
        base = q_ch.size();
        s_valid = 4'hF;
        tick(1);
        ch_en = 4'b0111;
        tick(6);
        s_valid = '0;
        tick(10);
        ch_en = 4'hF;
        tick(6);
        chk("t5_ch3_never", cnt_ch(base, 3), 0);
        chk("t5_ovf3", int'(ovf[3]), 0);
        chk("t5_others", (q_ch.size() - base) > 0 ? 1 : 0, 1);

        // 6: reset with two tags in flight; pointer must restart at N_CH-1.
        do_reset();
        for (int k = 0; k < N_CH; k++) set_dat(k, 100 * (k + 1));
        base = q_ch.size();
        s_valid = 4'b0011;
        tick(1);
        s_valid = '0;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("t6_m_valid_rel", int'(m_valid), 0);
        chk("t6_mix_in_rel", int'(mix_in), 0);
        tick(8);
        chk("t6_no_stale", q_ch.size() - base, 0);
        chk("t6_m_i", int'(m_i), 0);
        chk("t6_m_q", int'(m_q), 0);
        chk("t6_m_ch", int'(m_ch), 0);
        chk("t6_ovf", int'(ovf), 0);
        base = q_ch.size();
        s_valid = 4'hF;
        tick(1);
        s_valid = '0;
        tick(10);
        chk("t6_count", q_ch.size() - base, 4);
        if (q_ch.size() >= base + 2) begin
            chk("t6_first_ch", q_ch[base], 0);
            chk("t6_second_ch", q_ch[base+1], 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
